rs_chien_search: RTL and testbench
==================================

Name: rs_chien_search

Overview:
Chien-search stage of the Reed-Solomon decoder, between the Berlekamp-Massey (error-locator) stage and the Forney/correction stage.
- Evaluates the error-locator polynomial Λ(x) at every nonzero field element α^i, i = 0..2^m-2, in a single cycle.
- Compresses the root bitmap into up to T_LEN exponent values.
- Flags a decoding failure when the root count does not match deg Λ.

Parameters:
SYMB_WIDTH, 8, symbol width m in bits (from gf_pkg).
T_LEN, 8, maximum correctable symbol errors t (from gf_pkg).
ROOTS_PER_CYCLE, 2^SYMB_WIDTH-1, number of field elements evaluated per cycle. Only the single-cycle value is supported; any other value → $fatal at elaboration.
PRIM_POLY, 'h11D, field primitive polynomial (from gf_pkg).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
error_locator  in  [SYMB_WIDTH-1:0] x (T_LEN+1)  Λ coefficients; index k is the coefficient of x^k
error_locator_vld  in  1  single-cycle qualifier for error_locator
error_positions  out  [SYMB_WIDTH-1:0] x T_LEN  root exponents i with Λ(α^i)=0, in ascending order
error_positions_mask  out  T_LEN  per-slot valid bit (thermometer, LSB first)
error_positions_vld  out  1  one-cycle result strobe
rs_chien_err  out  1  failure flag, qualified by error_positions_vld

Behaviour:
- Reset (async, aresetn=0):
  - All output registers and pipeline valids clear to 0.
  - Reset asserted mid-operation discards in-flight results; no strobe is produced afterwards for that input.
- Stage 1 (edge sampling error_locator_vld=1):
  - Register bitmap r[i] = (Λ(α^i) == 0) for i = 0..ROOTS_PER_CYCLE-1.
  - GF multiply is polynomial product mod PRIM_POLY; GF add is XOR.
  - Register deg = index of the highest nonzero coefficient (0 if all zero), and a flag for "all coefficients zero".
- Stage 2 (next edge):
  - Decompose the bitmap into T_LEN one-hot vectors: slot j selects the j-th lowest set bit, using find-first-set with cascaded masking of bits already taken.
  - Each slot's one-hot vector drives a one-hot mux over the constants 0..ROOTS_PER_CYCLE-1.
  - Register the results into error_positions[j].
  - error_positions_mask[j] = 1 if slot j found a root.
  - Slots without a root output 0.
- Latency: error_positions_vld is high exactly one cycle, 2 cycles after the cycle in which error_locator_vld was sampled. Outputs hold until the next result.
- Pipelining: no back-pressure; a new locator is accepted every cycle; back-to-back inputs yield back-to-back strobes.
- rs_chien_err = 1 in any of these cases:
  - root count ≠ deg;
  - more than T_LEN roots exist (excess roots are dropped from the outputs);
  - Λ is all zero.
- Λ(0) is never evaluated, since 0 is not in the root set.

Decomposition:
- gf_pkg holds:
  - constants SYMB_WIDTH, T_LEN, SYMB_NUM = 2^SYMB_WIDTH, ROOTS_PER_CYCLE, PRIM_POLY;
  - functions alpha_to_symb (exponent → field element) and gf_mult;
  - poly_t typedef.
- One natural sub-module, rs_chien: a combinational evaluator taking roots[] and error_locator[] and producing error_bit_pos[ROOTS_PER_CYCLE-1:0].
- Decomposition and muxing reuse the library cells lib_decmps_to_pow2 (parameters WIDTH, FFS_NUM) and lib_mux_onehot (parameters PORTS_NUMBER, WIDTH).

Test Plan:
- Λ = {1,0,…}, vld pulse at cycle 0:
  - vld at cycle 2;
  - mask = 0, all positions 0, err = 0.
- Λ = {1, 0x01, 0…} (1+x) → position[0] = 0, mask = 0x01, err = 0.
- Λ = {1, 0x03, 0x02, 0…} = (1+x)(1+αx):
  - position[0] = 0, position[1] = 254, mask = 0x03, err = 0.
- Λ = {1, 0x00, 0x01, 0…} = (1+x)²:
  - a single root is found: position[0] = 0, mask = 0x01;
  - deg = 2 ≠ 1 → err = 1.
- The three valid vectors above driven on consecutive cycles → three consecutive strobes with matching results. Then all-zero Λ → err = 1.
- Assert aresetn low one cycle after a vld pulse → all outputs 0 and no strobe afterwards.

Source files
------------

// File: rtl/gf_pkg.sv
// GF(2^m) constants, types and arithmetic helpers shared by the Reed-Solomon decoder stages.
package gf_pkg;

  localparam int unsigned SYMB_WIDTH      = 8;
  localparam int unsigned T_LEN           = 8;
  localparam int unsigned SYMB_NUM        = 2 ** SYMB_WIDTH;
  localparam int unsigned ROOTS_PER_CYCLE = SYMB_NUM - 1;
  localparam int unsigned PRIM_POLY       = 'h11D;
  localparam int unsigned DEG_WIDTH       = $clog2(T_LEN + 1);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [T_LEN:0]       poly_t;

  // Shift-and-add product, reducing by the primitive polynomial as bits leave the top.
  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t p;
    symb_t x;
    p = '0;
    x = a;
    for (int n = 0; n < int'(SYMB_WIDTH); n++) begin
      if (b[n]) p = p ^ x;
      x = x[SYMB_WIDTH-1] ? ((x << 1) ^ SYMB_WIDTH'(PRIM_POLY)) : (x << 1);
    end
    return p;
  endfunction

  function automatic symb_t alpha_to_symb(input int unsigned pow);
    symb_t s;
    s = SYMB_WIDTH'(1);
    for (int unsigned n = 0; n < (pow % ROOTS_PER_CYCLE); n++) begin
      s = gf_mult(s, SYMB_WIDTH'(2));
    end
    return s;
  endfunction

endpackage

// File: rtl/lib_decmps_to_pow2.sv
// Splits a bit vector into FFS_NUM one-hot vectors, lowest set bit first; rest holds untaken bits.
module lib_decmps_to_pow2 #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned FFS_NUM = 2
) (
  input  logic [WIDTH-1:0]              data,
  output logic [FFS_NUM-1:0][WIDTH-1:0] onehot,
  output logic [WIDTH-1:0]              rest
);

  for (genvar j = 0; j < FFS_NUM; j++) begin : g_slot
    logic [WIDTH-1:0] rem_in;
    logic [WIDTH-1:0] oh;
    logic [WIDTH-1:0] rem_out;

    if (j == 0) begin : g_head
      assign rem_in = data;
    end else begin : g_tail
      assign rem_in = g_slot[j-1].rem_out;
    end

    // Two's-complement trick isolates the lowest set bit.
    assign oh      = rem_in & (~rem_in + WIDTH'(1));
    assign rem_out = rem_in & ~oh;
    assign onehot[j] = oh;
  end

  assign rest = g_slot[FFS_NUM-1].rem_out;

endmodule

// File: rtl/lib_mux_onehot.sv
// AND-OR multiplexer with a one-hot select; an all-zero select yields zero.
module lib_mux_onehot #(
  parameter int unsigned PORTS_NUMBER = 2,
  parameter int unsigned WIDTH        = 8
) (
  input  logic [PORTS_NUMBER-1:0]            sel,
  input  logic [PORTS_NUMBER-1:0][WIDTH-1:0] data,
  output logic [WIDTH-1:0]                   data_out
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [PORTS_NUMBER-1:0] column;
    for (genvar p = 0; p < PORTS_NUMBER; p++) begin : g_port
      assign column[p] = data[p][b];
    end
    assign data_out[b] = |(sel & column);
  end

endmodule

// File: rtl/rs_chien.sv
// Combinational evaluator: error_bit_pos[i] is set when the locator vanishes at roots[i].
module rs_chien
  import gf_pkg::*;
#(
  parameter int unsigned ROOTS = ROOTS_PER_CYCLE
) (
  input  logic [ROOTS-1:0][SYMB_WIDTH-1:0] roots,
  input  poly_t                            error_locator,
  output logic [ROOTS-1:0]                 error_bit_pos
);

  for (genvar i = 0; i < ROOTS; i++) begin : g_eval
    symb_t acc;

    // Horner evaluation from the highest coefficient down.
    always_comb begin
      acc = error_locator[T_LEN];
      for (int k = int'(T_LEN) - 1; k >= 0; k--) begin
        acc = gf_mult(acc, roots[i]) ^ error_locator[k];
      end
    end

    assign error_bit_pos[i] = (acc == '0);
  end

endmodule

// File: rtl/rs_chien_search.sv
// Chien search: two-stage pipeline turning an error locator into ascending root exponents.
module rs_chien_search #(
  parameter int unsigned ROOTS_PER_CYCLE = gf_pkg::ROOTS_PER_CYCLE
) (
  input  logic                                             aclk,
  input  logic                                             aresetn,
  input  gf_pkg::poly_t                                    error_locator,
  input  logic                                             error_locator_vld,
  output logic [gf_pkg::T_LEN-1:0][gf_pkg::SYMB_WIDTH-1:0] error_positions,
  output logic [gf_pkg::T_LEN-1:0]                         error_positions_mask,
  output logic                                             error_positions_vld,
  output logic                                             rs_chien_err
);

  localparam int unsigned W     = gf_pkg::SYMB_WIDTH;
  localparam int unsigned T     = gf_pkg::T_LEN;
  localparam int unsigned R     = ROOTS_PER_CYCLE;
  localparam int unsigned DEG_W = gf_pkg::DEG_WIDTH;

  if (ROOTS_PER_CYCLE != gf_pkg::ROOTS_PER_CYCLE) begin : g_bad_cfg
    $fatal(1, "rs_chien_search: only the single-cycle ROOTS_PER_CYCLE is supported");
  end

  logic [R-1:0][W-1:0] roots;
  logic [R-1:0][W-1:0] idx_const;
  logic [R-1:0]        bit_pos;

  // Root constants alpha^i built as a chain of multiply-by-alpha steps.
  for (genvar i = 0; i < R; i++) begin : g_root
    logic [W-1:0] val;
    if (i == 0) begin : g_first
      assign val = W'(1);
    end else begin : g_next
      assign val = gf_pkg::gf_mult(g_root[i-1].val, W'(2));
    end
    assign roots[i]     = val;
    assign idx_const[i] = W'(i);
  end

  rs_chien #(
    .ROOTS(R)
  ) u_chien (
    .roots        (roots),
    .error_locator(error_locator),
    .error_bit_pos(bit_pos)
  );

  logic             vld1_d,   vld1_q;
  logic [R-1:0]     bitmap_d, bitmap_q;
  logic [DEG_W-1:0] deg_d,    deg_q;
  logic             zero_d,   zero_q;

  // Stage 1: root bitmap, locator degree and all-zero flag.
  always_comb begin
    vld1_d   = error_locator_vld;
    bitmap_d = bitmap_q;
    deg_d    = deg_q;
    zero_d   = zero_q;
    if (error_locator_vld) begin
      bitmap_d = bit_pos;
      deg_d    = '0;
      zero_d   = 1'b1;
      for (int k = 0; k <= int'(T); k++) begin
        if (error_locator[k] != '0) begin
          deg_d  = DEG_W'(k);
          zero_d = 1'b0;
        end
      end
    end
  end

  logic [T-1:0][R-1:0] slot_onehot;
  logic [R-1:0]        slot_rest;
  logic [T-1:0][W-1:0] slot_pos;
  logic [T-1:0]        slot_found;

  lib_decmps_to_pow2 #(
    .WIDTH  (R),
    .FFS_NUM(T)
  ) u_decmps (
    .data  (bitmap_q),
    .onehot(slot_onehot),
    .rest  (slot_rest)
  );

  for (genvar j = 0; j < T; j++) begin : g_slot
    lib_mux_onehot #(
      .PORTS_NUMBER(R),
      .WIDTH       (W)
    ) u_mux (
      .sel     (slot_onehot[j]),
      .data    (idx_const),
      .data_out(slot_pos[j])
    );
    assign slot_found[j] = |slot_onehot[j];
  end

  logic [DEG_W-1:0] root_cnt_c;
  logic             chien_err_c;

  // Leftover bits after T slots means more roots than can be reported.
  always_comb begin
    root_cnt_c = '0;
    for (int j = 0; j < int'(T); j++) begin
      root_cnt_c = root_cnt_c + DEG_W'(slot_found[j]);
    end
    chien_err_c = zero_q | (|slot_rest) | (root_cnt_c != deg_q);
  end

  logic [T-1:0][W-1:0] pos_d,  pos_q;
  logic [T-1:0]        mask_d, mask_q;
  logic                err_d,  err_q;
  logic                ovld_d, ovld_q;

  // Stage 2: capture results on a strobe, otherwise hold.
  always_comb begin
    pos_d  = pos_q;
    mask_d = mask_q;
    err_d  = err_q;
    ovld_d = vld1_q;
    if (vld1_q) begin
      pos_d  = slot_pos;
      mask_d = slot_found;
      err_d  = chien_err_c;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld1_q   <= 1'b0;
      bitmap_q <= '0;
      deg_q    <= '0;
      zero_q   <= 1'b0;
      pos_q    <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
      ovld_q   <= 1'b0;
    end else begin
      vld1_q   <= vld1_d;
      bitmap_q <= bitmap_d;
      deg_q    <= deg_d;
      zero_q   <= zero_d;
      pos_q    <= pos_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      ovld_q   <= ovld_d;
    end
  end

  assign error_positions      = pos_q;
  assign error_positions_mask = mask_q;
  assign error_positions_vld  = ovld_q;
  assign rs_chien_err         = err_q;

endmodule

// File: tb/tb_rs_chien_search.sv
// Randomized bench for rs_chien_search against a log/antilog-table reference model.
module tb_rs_chien_search;

  typedef logic [8:0][7:0] loc_t;

  logic            aclk;
  logic            aresetn;
  loc_t            error_locator;
  logic            error_locator_vld;
  logic [7:0][7:0] error_positions;
  logic [7:0]      error_positions_mask;
  logic            error_positions_vld;
  logic            rs_chien_err;

  rs_chien_search dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .error_locator       (error_locator),
    .error_locator_vld   (error_locator_vld),
    .error_positions     (error_positions),
    .error_positions_mask(error_positions_mask),
    .error_positions_vld (error_positions_vld),
    .rs_chien_err        (rs_chien_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_t [255];
  int log_t [256];

  logic        prev_vld;
  logic [63:0] prev_pos,  last_pos;
  logic [7:0]  prev_mask, last_mask;
  logic        prev_err,  last_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Evaluate the locator at every alpha^i and list roots in ascending exponent order.
  task automatic model(input loc_t loc, output logic [63:0] pos,
                       output logic [7:0] mask, output logic err);
    int total;
    int deg;
    bit allz;
    total = 0;
    deg   = 0;
    allz  = 1;
    pos   = '0;
    mask  = '0;
    for (int k = 0; k < 9; k++) if (loc[k] != 0) begin deg = k; allz = 0; end
    for (int i = 0; i < 255; i++) begin
      int s;
      s = 0;
      for (int k = 0; k < 9; k++) s = s ^ gmul(int'(loc[k]), exp_t[(i * k) % 255]);
      if (s == 0) begin
        if (total < 8) begin
          pos[total*8 +: 8] = 8'(i);
          mask[total] = 1'b1;
        end
        total++;
      end
    end
    err = allz || (total > 8) || (total != deg);
  endtask

  // One clock: drive at negedge, check outputs just after the following posedge.
  task automatic step(input loc_t loc, input logic v);
    logic [63:0] cp;
    logic [7:0]  cm;
    logic        ce;
    cp = '0; cm = '0; ce = 1'b0;
    @(negedge aclk);
    error_locator     = loc;
    error_locator_vld = v;
    if (v) model(loc, cp, cm, ce);
    @(posedge aclk);
    #1;
    chk("vld", 64'(error_positions_vld), 64'(prev_vld));
    if (prev_vld) begin
      last_pos  = prev_pos;
      last_mask = prev_mask;
      last_err  = prev_err;
    end
    chk("positions", error_positions, last_pos);
    chk("mask", 64'(error_positions_mask), 64'(last_mask));
    chk("err", 64'(rs_chien_err), 64'(last_err));
    prev_vld  = v;
    prev_pos  = cp;
    prev_mask = cm;
    prev_err  = ce;
  endtask

  function automatic loc_t mk(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    loc_t l;
    l = '0;
    l[0] = c0;
    l[1] = c1;
    l[2] = c2;
    return l;
  endfunction

  // Product of (1 + a*x) factors with random nonzero a; duplicates are allowed.
  function automatic loc_t rand_prod(input int n);
    loc_t p;
    p = '0;
    p[0] = 8'h01;
    for (int m = 0; m < n; m++) begin
      int a;
      a = exp_t[$urandom_range(0, 254)];
      for (int k = 8; k >= 1; k--) p[k] = p[k] ^ 8'(gmul(a, int'(p[k-1])));
    end
    return p;
  endfunction

  function automatic loc_t rand_full();
    loc_t p;
    int d;
    p = '0;
    d = $urandom_range(0, 8);
    for (int k = 0; k <= d; k++) p[k] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  function automatic void clear_expect();
    prev_vld  = 1'b0;
    prev_pos  = '0;
    prev_mask = '0;
    prev_err  = 1'b0;
    last_pos  = '0;
    last_mask = '0;
    last_err  = 1'b0;
  endfunction

  initial begin
    int e;
    e = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e << 1;
      if (e >= 256) e = e ^ 'h11D;
    end
    log_t[0] = 0;
    clear_expect();

    aresetn           = 1'b0;
    error_locator     = '0;
    error_locator_vld = 1'b0;
    repeat (2) @(negedge aclk);
    chk("rst_vld", 64'(error_positions_vld), 64'(0));
    chk("rst_pos", error_positions, 64'(0));
    chk("rst_mask", 64'(error_positions_mask), 64'(0));
    chk("rst_err", 64'(rs_chien_err), 64'(0));
    aresetn = 1'b1;

    // No errors: strobe two cycles later with an empty result.
    step(mk(8'h01, 8'h00, 8'h00), 1'b1);
    step('0, 1'b0);
    step('0, 1'b0);
    step(mk(8'h01, 8'h01, 8'h00), 1'b1);
    step('0, 1'b0);
    step(mk(8'h01, 8'h03, 8'h02), 1'b1);
    step('0, 1'b0);
    step(mk(8'h01, 8'h00, 8'h01), 1'b1);
    step('0, 1'b0);
    step('0, 1'b0);

    // Back-to-back locators, then the all-zero locator.
    step(mk(8'h01, 8'h01, 8'h00), 1'b1);
    step(mk(8'h01, 8'h03, 8'h02), 1'b1);
    step(mk(8'h01, 8'h00, 8'h01), 1'b1);
    step('0, 1'b1);
    step('0, 1'b0);
    step('0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      loc_t l;
      logic v;
      case ($urandom_range(0, 9))
        0:       l = '0;
        1, 2, 3: l = rand_full();
        default: l = rand_prod($urandom_range(0, 8));
      endcase
      v = ($urandom_range(0, 3) != 0);
      step(l, v);
    end
    step('0, 1'b0);
    step('0, 1'b0);

    // Reset one cycle after a valid pulse drops the in-flight result.
    step(mk(8'h01, 8'h03, 8'h02), 1'b1);
    @(negedge aclk);
    error_locator_vld = 1'b0;
    aresetn           = 1'b0;
    #1;
    chk("midrst_vld", 64'(error_positions_vld), 64'(0));
    chk("midrst_pos", error_positions, 64'(0));
    chk("midrst_mask", 64'(error_positions_mask), 64'(0));
    chk("midrst_err", 64'(rs_chien_err), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    clear_expect();
    repeat (4) step('0, 1'b0);

    step(rand_prod(5), 1'b1);
    step('0, 1'b0);
    step('0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
